// File: rtl/sprite_compositor.sv
// ============================================================================
//  Module   : sprite_compositor
//  Purpose  : Composites NUM_SPR scaled, animated, chroma-keyed sprites over a
//             2x-upscaled background. All layers share one single-port SRAM
//             with one-cycle read latency; layers are read in priority order
//             (sprite 0 first, background last) within one pixel period.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_compositor #(
  parameter int          NUM_SPR     = 2,
  parameter int          ADDR_W      = 17,
  parameter int          BG_BASE     = 0,
  parameter int          BG_W        = 320,
  parameter int          SPR_W       = 64,
  parameter int          SPR_H       = 40,
  parameter int          SCALE_SH    = 1,
  parameter int          FRAMES      = 3,
  parameter int          ANIM_DIV    = 50000000,
  parameter logic [11:0] KEY         = 12'h0F0,
  parameter int          CLK_PER_PIX = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pixel_tick,
  input  logic                        video_on,
  input  logic [9:0]                  pixel_x,
  input  logic [9:0]                  pixel_y,
  input  logic [NUM_SPR-1:0]          spr_en,
  input  logic [NUM_SPR-1:0]          spr_anim,
  input  logic [10*NUM_SPR-1:0]       spr_x,
  input  logic [10*NUM_SPR-1:0]       spr_y,
  input  logic [ADDR_W*NUM_SPR-1:0]   spr_base,
  output logic [ADDR_W-1:0]           sram_addr,
  input  logic [11:0]                 sram_data,
  output logic [11:0]                 rgb_out,
  output logic                        rgb_valid,
  output logic                        overrun,
  output logic [2*NUM_SPR-1:0]        frame_idx
);

  localparam int LW       = $clog2(NUM_SPR + 1);
  localparam int CW       = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int SPR_SW   = SPR_W << SCALE_SH;
  localparam int SPR_SH   = SPR_H << SCALE_SH;
  localparam int FRAME_SZ = SPR_W * SPR_H;
  localparam logic [LW-1:0] BG_LAYER = LW'(NUM_SPR);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The worst case (all sprites keyed, background last) must fit in a pixel
  if (NUM_SPR + 2 > CLK_PER_PIX) begin : g_budget_err
    $error("sprite_compositor: NUM_SPR+2 exceeds CLK_PER_PIX");
  end

  logic [1:0]           state_q;
  logic [LW-1:0]        lay_q;
  logic [NUM_SPR-1:0]   mask_q;
  logic [9:0]           x_q, y_q;
  logic [2*NUM_SPR-1:0] frame_lat_q;
  logic [2*NUM_SPR-1:0] frame_q;
  logic [CW-1:0]        cnt_q;
  logic [11:0]          rgb_q;
  logic                 valid_q;
  logic                 overrun_q;

  // Cycle 0 works from the live coordinates; later reads use the latched copy
  logic [9:0]           w_cx, w_cy;
  logic [2*NUM_SPR-1:0] w_frm;
  logic [NUM_SPR-1:0]   w_hit;
  logic [ADDR_W-1:0]    w_spr_addr [NUM_SPR];
  logic [ADDR_W-1:0]    w_bg_addr;

  assign w_cx  = pixel_tick ? pixel_x : x_q;
  assign w_cy  = pixel_tick ? pixel_y : y_q;
  assign w_frm = pixel_tick ? frame_q : frame_lat_q;

  assign w_bg_addr = ADDR_W'(BG_BASE + (w_cy >> 1) * BG_W + (w_cx >> 1));

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
    logic [10:0] w_sx, w_sy, w_dx, w_dy, w_px, w_py;
    assign w_px = {1'b0, w_cx};
    assign w_py = {1'b0, w_cy};
    assign w_sx = {1'b0, spr_x[10*i +: 10]};
    assign w_sy = {1'b0, spr_y[10*i +: 10]};
    assign w_dx = w_px - w_sx;
    assign w_dy = w_py - w_sy;
    assign w_hit[i] = spr_en[i]
                      && (w_px >= w_sx) && (w_px < w_sx + 11'(SPR_SW))
                      && (w_py >= w_sy) && (w_py < w_sy + 11'(SPR_SH));
    assign w_spr_addr[i] = spr_base[ADDR_W*i +: ADDR_W]
                           + ADDR_W'(w_frm[2*i +: 2] * FRAME_SZ)
                           + ADDR_W'((w_dy >> SCALE_SH) * SPR_W)
                           + ADDR_W'(w_dx >> SCALE_SH);
  end

  // Highest-priority set layer, background when none remain
  function automatic logic [LW-1:0] prio(input logic [NUM_SPR-1:0] m);
    prio = BG_LAYER;
    for (int i = NUM_SPR - 1; i >= 0; i--)
      if (m[i]) prio = LW'(i);
  endfunction

  logic [NUM_SPR-1:0] w_mask_clr;
  logic [LW-1:0]      w_issue;
  logic               w_resolve;
  logic               w_drive;
  logic [ADDR_W-1:0]  w_issue_addr;

  // Pick the layer to address this cycle and decide whether the pixel resolves
  always_comb begin
    w_issue   = BG_LAYER;
    w_resolve = 1'b0;
    w_drive   = 1'b0;
    for (int i = 0; i < NUM_SPR; i++)
      w_mask_clr[i] = mask_q[i] && (lay_q != LW'(i));
    if (pixel_tick) begin
      w_issue = prio(w_hit);
      w_drive = video_on;
    end else if (state_q == S_READ) begin
      // Next layer is issued speculatively; it is ignored if this one resolves
      w_issue   = prio(w_mask_clr);
      w_resolve = (lay_q == BG_LAYER) || (sram_data != KEY);
      w_drive   = 1'b1;
    end
  end

  // Map the issued layer index onto its SRAM address
  always_comb begin
    w_issue_addr = w_bg_addr;
    for (int i = 0; i < NUM_SPR; i++)
      if (w_issue == LW'(i)) w_issue_addr = w_spr_addr[i];
  end

  assign sram_addr = w_drive ? w_issue_addr : ADDR_W'(BG_BASE);

  // Pixel FSM; a tick always restarts, and is an overrun only mid-read
  // (in DONE the previous pixel has already been delivered)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lay_q       <= BG_LAYER;
      mask_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      frame_lat_q <= '0;
      rgb_q       <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (pixel_tick) begin
        if (state_q == S_READ) overrun_q <= 1'b1;
        x_q         <= pixel_x;
        y_q         <= pixel_y;
        frame_lat_q <= frame_q;
        mask_q      <= w_hit;
        lay_q       <= w_issue;
        if (video_on) begin
          state_q <= S_READ;
        end else begin
          state_q <= S_DONE;
          rgb_q   <= '0;
          valid_q <= 1'b1;
        end
      end else begin
        case (state_q)
          S_READ: begin
            if (w_resolve) begin
              rgb_q   <= sram_data;
              valid_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              mask_q <= w_mask_clr;
              lay_q  <= w_issue;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Animation timebase: advance enabled sprites once per ANIM_DIV cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      frame_q <= '0;
    end else if (cnt_q == CW'(ANIM_DIV - 1)) begin
      cnt_q <= '0;
      for (int i = 0; i < NUM_SPR; i++)
        if (spr_anim[i])
          frame_q[2*i +: 2] <= (frame_q[2*i +: 2] == 2'(FRAMES - 1)) ? 2'd0
                               : frame_q[2*i +: 2] + 2'd1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign rgb_out   = rgb_q;
  assign rgb_valid = valid_q;
  assign overrun   = overrun_q;
  assign frame_idx = frame_q;

endmodule

`default_nettype wire
